// File: rtl/mem_subsystem.sv
// Direct-mapped write-through cache in front of a 256-word main memory with fixed latency.
// One LOAD or STORE is served at a time over a level handshake.
module mem_subsystem #(
  parameter int MEM_LATENCY = 10,
  parameter int LINES       = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] input_address,
  input  logic        LOAD,
  input  logic        STORE,
  input  logic [31:0] input_data,
  output logic [31:0] data,
  output logic        store_completed
);

  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 8 - OW - IW;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, LDONE, SDONE} state_t;

  state_t            state_reg;
  logic [7:0]        addr_reg;
  logic [31:0]       wdata_reg;
  logic [CW-1:0]     cnt_reg;
  logic [LINES-1:0]  valid_reg;
  logic [TW-1:0]     tag_mem  [LINES];
  logic [31:0]       line_mem [LINES][BLOCK_WORDS];

  // Main memory keeps its power-up contents (word i = i) until a word is first written.
  logic [255:0]      mem_written = '0;
  logic [31:0]       mem_words [256];

  logic [OW-1:0]     off;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic              last;
  logic              fill_done;
  logic              write_done;
  logic [31:0]       block_word [BLOCK_WORDS];
  logic              unused_addr;

  assign unused_addr = ^input_address[31:8];

  assign off        = addr_reg[OW-1:0];
  assign idx        = addr_reg[OW+IW-1:OW];
  assign tag        = addr_reg[7:OW+IW];
  assign hit        = valid_reg[idx] && (tag_mem[idx] == tag);
  assign last       = (cnt_reg == CW'(MEM_LATENCY - 1));
  assign fill_done  = (state_reg == FILL) && last;
  assign write_done = (state_reg == WRITE) && last;

  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_blk
    logic [7:0] waddr;
    assign waddr          = {addr_reg[7:OW], OW'(gi)};
    assign block_word[gi] = mem_written[waddr] ? mem_words[waddr] : {24'd0, waddr};
  end

  always_ff @(posedge CLK) begin
    if (write_done) begin
      mem_words[addr_reg]   <= wdata_reg;
      mem_written[addr_reg] <= 1'b1;
    end
  end

  // Fills replace the whole line; store hits patch a single word (no allocate on miss).
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[idx] <= tag;
      for (int i = 0; i < BLOCK_WORDS; i++)
        line_mem[idx][i] <= block_word[i];
    end else if (write_done && hit) begin
      line_mem[idx][off] <= wdata_reg;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      cnt_reg         <= '0;
      valid_reg       <= '0;
      data            <= '0;
      store_completed <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (LOAD) begin
            addr_reg  <= input_address[7:0];
            state_reg <= LOOKUP;
          end else if (STORE) begin
            addr_reg  <= input_address[7:0];
            wdata_reg <= input_data;
            state_reg <= WRITE;
          end
        end
        LOOKUP: begin
          if (hit) begin
            data      <= line_mem[idx][off];
            state_reg <= LDONE;
          end else begin
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (last) begin
            valid_reg[idx] <= 1'b1;
            data           <= block_word[off];
            state_reg      <= LDONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WRITE: begin
          if (last) begin
            store_completed <= 1'b1;
            state_reg       <= SDONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LDONE: begin
          if (!LOAD) state_reg <= IDLE;
        end
        SDONE: begin
          if (!STORE) begin
            store_completed <= 1'b0;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem: a vector table of loads/stores with exact latencies,
// plus hand-written sequences for load priority and reset during a fill or a write.
module tb_mem_subsystem;

  logic        CLK;
  logic        RST;
  logic [31:0] input_address;
  logic        LOAD;
  logic        STORE;
  logic [31:0] input_data;
  logic [31:0] data;
  logic        store_completed;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_data;

  mem_subsystem dut (
    .CLK             (CLK),
    .RST             (RST),
    .input_address   (input_address),
    .LOAD            (LOAD),
    .STORE           (STORE),
    .input_data      (input_data),
    .data            (data),
    .store_completed (store_completed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Address/data are scrambled after edge 0 to show they are latched at request time.
  task automatic run_load(input logic [31:0] a, input logic [31:0] exp, input int lat, input string name);
    @(negedge CLK);
    input_address = a;
    LOAD = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    input_address = ~a;
    repeat (lat - 1) @(posedge CLK);
    #1;
    if (prev_data != exp) check(data == prev_data, {name, "_early"}, data, prev_data);
    @(posedge CLK);
    #1;
    check(data == exp, name, data, exp);
    check(store_completed == 1'b0, {name, "_sc"}, {31'd0, store_completed}, 32'd0);
    $display("load  %08h -> %08h (lat %0d) %s", a, data, lat, name);
    @(negedge CLK);
    LOAD = 1'b0;
    @(posedge CLK);
    prev_data = exp;
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] wd, input int lat, input string name);
    @(negedge CLK);
    input_address = a;
    input_data = wd;
    STORE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    input_address = ~a;
    input_data = ~wd;
    repeat (lat - 1) @(posedge CLK);
    #1;
    check(store_completed == 1'b0, {name, "_early"}, {31'd0, store_completed}, 32'd0);
    @(posedge CLK);
    #1;
    check(store_completed == 1'b1, name, {31'd0, store_completed}, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    check(store_completed == 1'b1, {name, "_held"}, {31'd0, store_completed}, 32'd1);
    check(data == prev_data, {name, "_data"}, data, prev_data);
    @(negedge CLK);
    STORE = 1'b0;
    @(posedge CLK);
    #1;
    check(store_completed == 1'b0, {name, "_fall"}, {31'd0, store_completed}, 32'd0);
    $display("store %08h <- %08h (lat %0d) %s", a, wd, lat, name);
  endtask

  initial begin
    RST = 1'b1;
    LOAD = 1'b0;
    STORE = 1'b0;
    input_address = '0;
    input_data = '0;
    prev_data = '0;

    vecs[0]  = '{0, 32'h08, 32'h0, 32'h00000008, 11, "cold_miss_08"};
    vecs[1]  = '{0, 32'h09, 32'h0, 32'h00000009, 1,  "hit_09"};
    vecs[2]  = '{1, 32'h19, 32'hDEADBEEF, 32'h0, 10, "store_miss_19"};
    vecs[3]  = '{0, 32'h19, 32'h0, 32'hDEADBEEF, 11, "load_19_no_alloc"};
    vecs[4]  = '{1, 32'h1A, 32'h12345678, 32'h0, 10, "store_hit_1a"};
    vecs[5]  = '{0, 32'h1A, 32'h0, 32'h12345678, 1,  "hit_1a_updated"};
    vecs[6]  = '{0, 32'h1B, 32'h0, 32'h0000001B, 1,  "hit_1b"};
    vecs[7]  = '{0, 32'h28, 32'h0, 32'h00000028, 11, "conflict_28"};
    vecs[8]  = '{0, 32'h08, 32'h0, 32'h00000008, 11, "evicted_08"};
    vecs[9]  = '{0, 32'hABCD0109, 32'h0, 32'h00000009, 1, "alias_09"};
    vecs[10] = '{0, 32'h09, 32'h0, 32'h00000009, 1,  "same_value_09"};
    vecs[11] = '{1, 32'h48, 32'hCAFEF00D, 32'h0, 10, "store_other_tag_48"};
    vecs[12] = '{0, 32'h08, 32'h0, 32'h00000008, 1,  "line2_untouched_08"};
    vecs[13] = '{0, 32'h48, 32'h0, 32'hCAFEF00D, 11, "load_48"};

    #12;
    check(data == 32'd0, "reset_data", data, 32'd0);
    check(store_completed == 1'b0, "reset_sc", {31'd0, store_completed}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_store) run_store(vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].name);
      else                  run_load(vecs[i].addr, vecs[i].exp, vecs[i].lat, vecs[i].name);
    end

    // LOAD wins over a simultaneous STORE; the store must never complete.
    @(negedge CLK);
    input_address = 32'h1A;
    input_data = 32'h0BADF00D;
    LOAD = 1'b1;
    STORE = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check(data == 32'h12345678, "priority_load", data, 32'h12345678);
    repeat (12) @(posedge CLK);
    #1;
    check(store_completed == 1'b0, "priority_no_store", {31'd0, store_completed}, 32'd0);
    $display("load+store %08h -> %08h priority", 32'h1A, data);
    @(negedge CLK);
    LOAD = 1'b0;
    STORE = 1'b0;
    @(posedge CLK);
    prev_data = 32'h12345678;
    run_load(32'h1A, 32'h12345678, 1, "priority_mem_intact");

    // Reset in the middle of a fill.
    @(negedge CLK);
    input_address = 32'h30;
    LOAD = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    LOAD = 1'b0;
    #1;
    check(data == 32'd0, "rst_fill_data", data, 32'd0);
    check(store_completed == 1'b0, "rst_fill_sc", {31'd0, store_completed}, 32'd0);
    $display("reset during fill of %08h", 32'h30);
    @(negedge CLK);
    RST = 1'b0;
    prev_data = '0;
    run_load(32'h30, 32'h00000030, 11, "after_rst_30");
    run_load(32'h08, 32'h00000008, 11, "after_rst_08_invalid");

    // Reset in the middle of a write: memory must keep its old word.
    @(negedge CLK);
    input_address = 32'h50;
    input_data = 32'h55555555;
    STORE = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    STORE = 1'b0;
    #1;
    check(store_completed == 1'b0, "rst_write_sc", {31'd0, store_completed}, 32'd0);
    $display("reset during write of %08h", 32'h50);
    @(negedge CLK);
    RST = 1'b0;
    prev_data = '0;
    run_load(32'h50, 32'h00000050, 11, "after_rst_50_unwritten");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
